// File: rtl/multi_player_clock_pkg.sv
// Shared types and width helpers for the multi-player game clock.
// Imported by the interface, the prescaler and the top.
package game_clock_pkg;

  typedef enum logic [1:0] {
    S_SETUP,
    S_RUN,
    S_PAUSE,
    S_FLAG
  } state_e;

  localparam logic [1:0] MODE_SD      = 2'd0;
  localparam logic [1:0] MODE_FISCHER = 2'd1;
  localparam logic [1:0] MODE_DELAY   = 2'd2;

  function automatic int pw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int tw_of(input int max_sec);
    return (max_sec > 0) ? $clog2(max_sec + 1) : 1;
  endfunction

  function automatic int dw_of(input int d);
    return (d > 0) ? $clog2(d + 1) : 1;
  endfunction

endpackage

// File: rtl/multi_player_clock_if.sv
// Button inputs and display-facing outputs of the game clock.
// master drives buttons, slave is the clock engine.
interface multi_player_clock_if
  import game_clock_pkg::*;
#(
  parameter int N_PLAYERS = 2,
  parameter int MAX_SEC   = 5999
);
  localparam int PW = pw_of(N_PLAYERS);
  localparam int TW = tw_of(MAX_SEC);

  logic                      start;
  logic                      pause;
  logic                      turn_done;
  logic                      sel_next;
  logic                      min_up;
  logic                      min_dn;
  logic                      sec_up;
  logic                      sec_dn;
  logic [1:0]                mode;
  logic [N_PLAYERS*TW-1:0]   time_flat;
  logic [PW-1:0]             active;
  logic [PW-1:0]             cursor;
  logic                      running;
  logic                      in_delay;
  logic [N_PLAYERS-1:0]      flag;

  modport master (
    output start, pause, turn_done, sel_next,
    output min_up, min_dn, sec_up, sec_dn, mode,
    input  time_flat, active, cursor,
    input  running, in_delay, flag
  );

  modport slave (
    input  start, pause, turn_done, sel_next,
    input  min_up, min_dn, sec_up, sec_dn, mode,
    output time_flat, active, cursor,
    output running, in_delay, flag
  );

endinterface

// File: rtl/multi_player_clock_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1 while enabled.
// tick marks the terminal count; clr restarts the second.
module sec_tick_gen #(
  parameter int CLK_HZ = 125_000_000
) (
  input  logic clk,
  input  logic btnC,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // Prescaler register; holds while disabled so a pause keeps the fraction.
  always_ff @(posedge clk) begin
    if (btnC) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multi_player_clock.sv
// N-player game clock: per-player banks, shared countdown, turn rotation.
// Sudden-death, Fischer and simple-delay modes; flags the loser.
module multi_player_clock
  import game_clock_pkg::*;
#(
  parameter int N_PLAYERS   = 2,
  parameter int CLK_HZ      = 125_000_000,
  parameter int MAX_SEC     = 5999,
  parameter int DEFAULT_SEC = 300,
  parameter int INC_SEC     = 2,
  parameter int DELAY_SEC   = 3
) (
  input  logic               clk,
  input  logic               btnC,
  multi_player_clock_if.slave bus
);
  localparam int PW = pw_of(N_PLAYERS);
  localparam int TW = tw_of(MAX_SEC);
  localparam int DW = dw_of(DELAY_SEC);

  localparam logic [TW-1:0] T_DEF = TW'(DEFAULT_SEC);
  localparam logic [PW-1:0] P_LAST = PW'(N_PLAYERS - 1);
  localparam logic [DW-1:0] D_RLD = DW'(DELAY_SEC);

  state_e                         state_q, state_d;
  logic [N_PLAYERS-1:0][TW-1:0]   bank_q, bank_d;
  logic [PW-1:0]                  active_q, active_d;
  logic [PW-1:0]                  cursor_q, cursor_d;
  logic [N_PLAYERS-1:0]           flag_q, flag_d;
  logic [1:0]                     mode_q, mode_d;
  logic [DW-1:0]                  dly_q, dly_d;
  logic                           running_q;
  logic                           in_delay_q;

  logic                           all_set;
  logic [1:0]                     mode_in;
  logic [TW-1:0]                  dec;
  logic                           en;
  logic                           clr;
  logic                           tick;

  // Saturating add of a signed step, clamped to 0..MAX_SEC.
  function automatic logic [TW-1:0] sat_add(
    input logic [TW-1:0] b,
    input int            k
  );
    int s;
    s = int'(b) + k;
    if (s > MAX_SEC) s = MAX_SEC;
    if (s < 0)       s = 0;
    return TW'(s);
  endfunction

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk  (clk),
    .btnC (btnC),
    .en   (en),
    .clr  (clr),
    .tick (tick)
  );

  assign mode_in = (bus.mode == 2'd3) ? MODE_SD : bus.mode;

  // A game may only start when no player has an empty bank.
  always_comb begin
    all_set = 1'b1;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (bank_q[i] == '0) all_set = 1'b0;
    end
  end

  // Next state, bank edits, countdown and turn handover.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    active_d = active_q;
    cursor_d = cursor_q;
    flag_d   = flag_q;
    mode_d   = mode_q;
    dly_d    = dly_q;
    en       = 1'b0;
    clr      = 1'b0;
    dec      = bank_q[active_q] - TW'(1);
    unique case (state_q)
      S_SETUP: begin
        if (bus.min_up) begin
          bank_d[cursor_q] = sat_add(bank_q[cursor_q], 60);
        end else if (bus.min_dn) begin
          bank_d[cursor_q] = sat_add(bank_q[cursor_q], -60);
        end else if (bus.sec_up) begin
          bank_d[cursor_q] = sat_add(bank_q[cursor_q], 1);
        end else if (bus.sec_dn) begin
          bank_d[cursor_q] = sat_add(bank_q[cursor_q], -1);
        end
        if (bus.sel_next) begin
          cursor_d = (cursor_q == P_LAST) ? '0 : cursor_q + PW'(1);
        end
        if (bus.start && all_set) begin
          mode_d   = mode_in;
          active_d = '0;
          clr      = 1'b1;
          dly_d    = (mode_in == MODE_DELAY) ? D_RLD : '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.pause) begin
          state_d = S_PAUSE;
        end else begin
          en = 1'b1;
          if (tick) begin
            if (dly_q != '0) begin
              dly_d = dly_q - DW'(1);
            end else begin
              bank_d[active_q] = dec;
              if (dec == '0) begin
                flag_d[active_q] = 1'b1;
                state_d          = S_FLAG;
              end
            end
          end
          if (bus.turn_done && state_d != S_FLAG) begin
            if (mode_q == MODE_FISCHER) begin
              bank_d[active_q] = sat_add(bank_d[active_q], INC_SEC);
            end
            active_d = (active_q == P_LAST) ? '0 : active_q + PW'(1);
            clr      = 1'b1;
            dly_d    = (mode_q == MODE_DELAY) ? D_RLD : '0;
          end
        end
      end
      S_PAUSE: begin
        if (!bus.pause) state_d = S_RUN;
      end
      S_FLAG: begin
      end
    endcase
  end

  // State and datapath registers; outputs come straight from here.
  always_ff @(posedge clk) begin
    if (btnC) begin
      state_q    <= S_SETUP;
      bank_q     <= {N_PLAYERS{T_DEF}};
      active_q   <= '0;
      cursor_q   <= '0;
      flag_q     <= '0;
      mode_q     <= MODE_SD;
      dly_q      <= '0;
      running_q  <= 1'b0;
      in_delay_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      active_q   <= active_d;
      cursor_q   <= cursor_d;
      flag_q     <= flag_d;
      mode_q     <= mode_d;
      dly_q      <= dly_d;
      running_q  <= (state_d == S_RUN);
      in_delay_q <= (state_d == S_RUN) && (dly_d != '0);
    end
  end

  assign bus.time_flat = bank_q;
  assign bus.active    = active_q;
  assign bus.cursor    = cursor_q;
  assign bus.running   = running_q;
  assign bus.in_delay  = in_delay_q;
  assign bus.flag      = flag_q;

endmodule
